// File: rtl/fusion_zbt_pkg.sv
// Shared ZBT constants and the FIFO entry layout used by the bank-1 write path.
package fusion_zbt_pkg;
  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;
  localparam int ZBT_WR_LAT = 2;
  localparam int PIX_W      = 18;
  localparam int CH_W       = 6;
  localparam int ENTRY_W    = ZBT_ADDR_W + ZBT_DATA_W;

  typedef struct packed {
    logic [ZBT_ADDR_W-1:0] addr;
    logic [ZBT_DATA_W-1:0] data;
  } zbt_entry_t;
endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO of {addr, data} entries; pointers carry one extra wrap bit.
module pix_fifo
  import fusion_zbt_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       push_i,
  input  zbt_entry_t wr_entry_i,
  input  logic       pop_i,
  output zbt_entry_t rd_entry_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [AW:0] level_o
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  zbt_entry_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;

  always_comb begin
    level_o    = wr_ptr_q - rd_ptr_q;
    full_o     = (level_o == FULL_LVL);
    empty_o    = (level_o == '0);
    pop_ok     = pop_i && !empty_o;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    push_ok    = push_i && (!full_o || pop_ok);
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_entry_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_i;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/zbt_proc_writer.sv
// Captures processed pixel pairs on address change, queues them and writes them to
// ZBT bank 1 in the gaps left by display reads, with data delayed by the write latency.
module zbt_proc_writer
  import fusion_zbt_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int WR_LAT = ZBT_WR_LAT,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ZBT_DATA_W-1:0] proc_pixs,
  input  logic [ZBT_ADDR_W-1:0] proc_addr,
  input  logic                  disp_req,
  input  logic [ZBT_ADDR_W-1:0] disp_addr,
  input  logic                  clear_ovf,
  output logic [ZBT_ADDR_W-1:0] zbt_addr,
  output logic                  zbt_we,
  output logic [ZBT_DATA_W-1:0] zbt_wdata,
  output logic                  zbt_wdata_oe,
  output logic [LW-1:0]         fifo_level,
  output logic                  overflow
);
  logic [ZBT_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic                  have_last_q, have_last_d;
  logic                  ovf_q, ovf_d;
  logic [ZBT_ADDR_W-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  // Stage 0 is loaded on the write-enable edge; stage WR_LAT drives the bus.
  logic [WR_LAT:0][ZBT_DATA_W-1:0] pipe_data_q, pipe_data_d;
  logic [WR_LAT:0]                 pipe_vld_q, pipe_vld_d;

  logic       capture, push, pop, drop, full, empty;
  zbt_entry_t head, wr_entry;

  pix_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_ni    (reset),
    .push_i    (push),
    .wr_entry_i(wr_entry),
    .pop_i     (pop),
    .rd_entry_o(head),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (fifo_level)
  );

  always_comb begin
    wr_entry    = '{addr: proc_addr, data: proc_pixs};
    capture     = !have_last_q || (proc_addr != last_addr_q);
    pop         = !disp_req && !empty;
    push        = capture && (!full || pop);
    drop        = capture && full && !pop;
    last_addr_d = capture ? proc_addr : last_addr_q;
    have_last_d = have_last_q || capture;
    // A drop on the same edge as a clear leaves the flag set.
    ovf_d       = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
    addr_d      = addr_q;
    we_d        = 1'b0;
    if (disp_req) begin
      addr_d = disp_addr;
    end else if (pop) begin
      addr_d = head.addr;
      we_d   = 1'b1;
    end
    pipe_data_d = {pipe_data_q[WR_LAT-1:0], (pop ? head.data : '0)};
    pipe_vld_d  = {pipe_vld_q[WR_LAT-1:0], pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_q <= '0;
      have_last_q <= 1'b0;
      ovf_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      pipe_data_q <= '0;
      pipe_vld_q  <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      have_last_q <= have_last_d;
      ovf_q       <= ovf_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      pipe_data_q <= pipe_data_d;
      pipe_vld_q  <= pipe_vld_d;
    end
  end

  assign zbt_addr     = addr_q;
  assign zbt_we       = we_q;
  assign zbt_wdata    = pipe_data_q[WR_LAT];
  assign zbt_wdata_oe = pipe_vld_q[WR_LAT];
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_zbt_proc_writer.sv
// Directed and random stimulus against a queue-based reference of the bank-1 write path.
module tb_zbt_proc_writer;
  localparam int DEPTH  = 8;
  localparam int WR_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] proc_pixs;
  logic [18:0] proc_addr;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        clear_ovf;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_wdata;
  logic        zbt_wdata_oe;
  logic [3:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // Reference state: pending writes, capture memory, bus outputs, latency history.
  logic [54:0] m_q[$];
  logic [36:0] m_hist[$];
  logic        m_have;
  logic [18:0] m_last;
  logic [18:0] m_addr;
  logic        m_we;
  logic        m_ovf;
  logic        m_oe;
  logic [35:0] m_wdata;

  zbt_proc_writer #(.DEPTH(DEPTH), .WR_LAT(WR_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .proc_pixs   (proc_pixs),
    .proc_addr   (proc_addr),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .clear_ovf   (clear_ovf),
    .zbt_addr    (zbt_addr),
    .zbt_we      (zbt_we),
    .zbt_wdata   (zbt_wdata),
    .zbt_wdata_oe(zbt_wdata_oe),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hist.delete();
    for (int i = 0; i < WR_LAT; i++) m_hist.push_back('0);
    m_have  = 1'b0;
    m_last  = '0;
    m_addr  = '0;
    m_we    = 1'b0;
    m_ovf   = 1'b0;
    m_oe    = 1'b0;
    m_wdata = '0;
  endtask

  task automatic model_edge();
    logic        pop, cap, drop;
    logic [54:0] ent;
    int          sz0;
    if (!reset) return;
    sz0  = m_q.size();
    pop  = !disp_req && (sz0 > 0);
    ent  = '0;
    if (pop) ent = m_q.pop_front();
    cap  = !m_have || (proc_addr != m_last);
    drop = 1'b0;
    if (disp_req) begin
      m_addr = disp_addr;
      m_we   = 1'b0;
    end else begin
      if (pop) m_addr = ent[54:36];
      m_we = pop;
    end
    if (cap) begin
      if (sz0 == DEPTH && !pop) drop = 1'b1;
      else m_q.push_back({proc_addr, proc_pixs});
      m_last = proc_addr;
      m_have = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;
    m_hist.push_back({pop, ent[35:0]});
    {m_oe, m_wdata} = m_hist.pop_front();
  endtask

  task automatic check_all();
    chk("zbt_addr", 64'(zbt_addr), 64'(m_addr));
    chk("zbt_we", 64'(zbt_we), 64'(m_we));
    chk("zbt_wdata_oe", 64'(zbt_wdata_oe), 64'(m_oe));
    if (m_oe) chk("zbt_wdata", 64'(zbt_wdata), 64'(m_wdata));
    chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int we_cnt, we_at, oe_at;
    reset     = 1'b0;
    proc_pixs = 36'h123456789;
    proc_addr = 19'h00010;
    disp_req  = 1'b0;
    disp_addr = '0;
    clear_ovf = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_wdata", 64'(zbt_wdata), 64'h0);
    repeat (2) step();
    reset = 1'b1;

    // Single held address: one write, fixed latency.
    we_cnt = 0; we_at = 0; oe_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      we_cnt += int'(zbt_we);
      if (zbt_we && we_at == 0) we_at = i;
      if (zbt_wdata_oe && oe_at == 0) oe_at = i;
    end
    chk("s1_write_count", 64'(we_cnt), 64'd1);
    chk("s1_we_edge", 64'(we_at), 64'd2);
    chk("s1_oe_edge", 64'(oe_at), 64'(2 + WR_LAT));

    // Four one-cycle addresses back to back.
    for (int a = 1; a <= 4; a++) begin
      proc_addr = 19'(a);
      proc_pixs = 36'($urandom) ^ {4'(a), 32'h0};
      step();
    end
    repeat (8) step();

    // Display holds the bus while the FIFO fills and then overflows.
    disp_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      proc_addr = 19'h100 + 19'(i);
      proc_pixs = {4'(i), 32'($urandom)};
      disp_addr = 19'($urandom);
      step();
      if (i == 7) chk("s3_level_full", 64'(fifo_level), 64'd8);
    end
    chk("s3_overflow_set", 64'(overflow), 64'd1);
    disp_addr = 19'($urandom);
    step();
    disp_req = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      we_cnt += int'(zbt_we);
    end
    chk("s3_drain_writes", 64'(we_cnt), 64'd8);
    chk("s3_overflow_sticky", 64'(overflow), 64'd1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("s3_overflow_clear", 64'(overflow), 64'd0);

    // Full FIFO accepts a capture on the same edge as a pop.
    disp_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      proc_addr = 19'h200 + 19'(i);
      proc_pixs = 36'($urandom);
      step();
    end
    proc_addr = 19'h208;
    proc_pixs = 36'h0_CAFE_F00D;
    disp_req  = 1'b0;
    step();
    chk("s4_level_stays", 64'(fifo_level), 64'd8);
    chk("s4_no_overflow", 64'(overflow), 64'd0);
    repeat (12) step();

    // Reset right after a write enable abandons its data phase.
    proc_addr = 19'h300;
    proc_pixs = 36'h9_8765_4321;
    step();
    step();
    chk("s5_we_before_reset", 64'(zbt_we), 64'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("s5_rst_we", 64'(zbt_we), 64'd0);
    chk("s5_rst_addr", 64'(zbt_addr), 64'd0);
    chk("s5_rst_wdata", 64'(zbt_wdata), 64'd0);
    repeat (3) step();
    reset = 1'b1;
    we_at = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (zbt_we && we_at == 0) begin
        we_at = i;
        chk("s5_recapture_addr", 64'(zbt_addr), 64'h300);
      end
    end
    chk("s5_recapture_edge", 64'(we_at), 64'd2);

    // Alternating display requests with three queued entries.
    disp_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      proc_addr = 19'h400 + 19'(i);
      proc_pixs = 36'($urandom);
      disp_addr = 19'($urandom);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      disp_req  = (i % 2 == 1);
      disp_addr = 19'($urandom);
      step();
      if (disp_req) begin
        chk("s6_req_we", 64'(zbt_we), 64'd0);
        chk("s6_req_addr", 64'(zbt_addr), 64'(disp_addr));
      end
    end
    disp_req = 1'b0;
    repeat (4) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) proc_addr = 19'($urandom_range(0, 15));
      proc_pixs = {4'($urandom), 32'($urandom)};
      disp_req  = ($urandom_range(0, 9) < 5);
      disp_addr = 19'($urandom);
      clear_ovf = ($urandom_range(0, 19) == 0);
      step();
    end
    clear_ovf = 1'b0;
    disp_req  = 1'b0;
    repeat (12) step();
    chk("final_empty", 64'(fifo_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
